// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive sweep of a small combinational block.
// Drives every input code onto the block under test, samples its response
// after a programmable settle time, compares against a packed expected truth
// table and reports pass/fail, mismatch count and the lowest failing code.
module truth_table_checker #(
    parameter int unsigned                        N_IN     = 4,
    parameter int unsigned                        N_OUT    = 2,
    parameter logic [(2**N_IN)*N_OUT-1:0]         EXPECTED = 32'hE4E4_E4E4,
    parameter int unsigned                        SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail
);

    localparam int unsigned     N_CODES   = 2**N_IN;
    localparam int unsigned     SW        = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [N_IN-1:0] LAST_CODE = '1;
    localparam logic [N_IN:0]   ERR_MAX   = (N_IN+1)'(N_CODES);
    localparam logic [SW-1:0]   SETTLE_END = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CHECK,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              pass_q, pass_d;
    logic              mismatch;

    // Expected truth table unpacked so the slice is selected by stim alone.
    logic [N_OUT-1:0]  exp_tbl [N_CODES];

    for (genvar g = 0; g < N_CODES; g++) begin : g_tbl
        assign exp_tbl[g] = EXPECTED[g*N_OUT +: N_OUT];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: hold each code SETTLE cycles, check once, stop after the last code.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_APPLY;
            S_APPLY: if (settle_q == SETTLE_END) state_d = S_CHECK;
            S_CHECK: state_d = (stim_q == LAST_CODE) ? S_DONE : S_APPLY;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Datapath next values: stimulus stepping, settle timing, result accumulation.
    always_comb begin
        stim_d   = stim_q;
        settle_d = settle_q;
        err_d    = err_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        mismatch = (resp != exp_tbl[stim_q]);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    stim_d   = '0;
                    settle_d = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    pass_d   = 1'b0;
                end
            end
            S_APPLY: begin
                settle_d = settle_q + 1'b1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                    if (err_q == '0)      ff_d  = stim_q;
                end
                if (stim_q != LAST_CODE) begin
                    stim_d   = stim_q + 1'b1;
                    settle_d = '0;
                end else begin
                    // Final verdict must include the comparison made on this edge.
                    pass_d = (err_q == '0) && !mismatch;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q   <= '0;
            settle_q <= '0;
            err_q    <= '0;
            ff_q     <= '0;
            pass_q   <= 1'b0;
        end else begin
            stim_q   <= stim_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            ff_q     <= ff_d;
            pass_q   <= pass_d;
        end
    end

    assign stim       = stim_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed and randomized fault patterns on a
// loopback block, plus a registered block swept with two settle settings.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start0, start1;
    logic [3:0] stim0, stim1;
    logic [1:0] resp0, resp1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [4:0] err0, err1;
    logic [3:0] ff0, ff1;

    logic [1:0] mask [16];
    logic       delay_mode;
    logic [3:0] d1_0, d2_0, d1_1, d2_1;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    truth_table_checker dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stim(stim0), .resp(resp0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0)
    );

    truth_table_checker #(.SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1), .resp(resp1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1)
    );

    // Block under test for dut1 (and dut0 in delay mode): stim[1:0] through two registers.
    always_ff @(posedge clk) begin
        d1_0 <= stim0;
        d2_0 <= d1_0;
        d1_1 <= stim1;
        d2_1 <= d1_1;
    end

    // Block under test for dut0: loopback with a per-code flip mask, or the delayed path.
    always_comb begin
        resp0 = delay_mode ? d2_0[1:0] : (stim0[1:0] ^ mask[stim0]);
    end
    assign resp1 = d2_1[1:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: count codes whose loopback response is disturbed by the mask.
    function automatic void model(output int unsigned nerr, output int unsigned first);
        nerr  = 0;
        first = 0;
        for (int c = 0; c < 16; c++) begin
            int unsigned seen;
            seen = (c % 4) ^ int'(mask[c]);
            if (seen != (c % 4)) begin
                if (nerr == 0) first = c;
                nerr++;
            end
        end
    endfunction

    // One sweep from start request through the first IDLE cycle after DONE.
    // hold = SETTLE+1 cycles per code; returns on the first IDLE cycle's negedge.
    task automatic run_sweep(input bit sel, input int unsigned hold, input bit junk,
                             input int unsigned exp_err, input int unsigned exp_first,
                             input string name);
        int unsigned len;
        int unsigned dones;
        int unsigned code;
        len   = 16 * hold;
        dones = 0;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        for (int unsigned j = 0; j <= len + 1; j++) begin
            code = (j / hold > 15) ? 15 : j / hold;
            check({name, ":stim"}, sel ? stim1 : stim0, code);
            check({name, ":busy"}, sel ? busy1 : busy0, (j <= len));
            check({name, ":done"}, sel ? done1 : done0, (j == len));
            if (sel ? done1 : done0) dones++;
            if (j >= len) begin
                check({name, ":pass"}, sel ? pass1 : pass0, (exp_err == 0));
                check({name, ":err_count"}, sel ? err1 : err0, exp_err);
                if (exp_err != 0)
                    check({name, ":first_fail"}, sel ? ff1 : ff0, exp_first);
            end
            if (junk) start0 = (j < len) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (j < len + 1) @(negedge clk);
        end
        check({name, ":done_pulses"}, dones, 1);
    endtask

    initial begin
        int unsigned ne, nf, w;
        rst_n      = 1'b0;
        start0     = 1'b1;
        start1     = 1'b1;
        delay_mode = 1'b0;
        foreach (mask[i]) mask[i] = 2'b00;

        // Reset held with start asserted: everything reads zero.
        repeat (3) @(negedge clk);
        check("rst_dut0", {stim0, busy0, done0, pass0, err0, ff0}, 0);
        check("rst_dut1", {stim1, busy1, done1, pass1, err1, ff1}, 0);
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n  = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy0", busy0, 0);
        check("idle_stim0", stim0, 0);
        check("idle_busy1", busy1, 0);

        // Clean loopback.
        run_sweep(0, 2, 0, 0, 0, "loop");

        // Output stuck at 00: every code with stim[1:0] != 0 fails.
        for (int c = 0; c < 16; c++) mask[c] = 2'(c);
        run_sweep(0, 2, 0, 12, 1, "stuck");

        // Single inverted response at code A.
        foreach (mask[i]) mask[i] = 2'b00;
        mask[10] = 2'b11;
        run_sweep(0, 2, 0, 1, 10, "single");

        // Start hammered while busy (and during DONE): exactly one sweep.
        mask[10] = 2'b00;
        run_sweep(0, 2, 1, 0, 0, "junk_start");

        // Random sparse fault patterns, back to back.
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 16; c++)
                mask[c] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            model(ne, nf);
            run_sweep(0, 2, 0, ne, nf, "rand");
        end

        // Two-register block with SETTLE=1: each sample sees the previous code,
        // and code 0 sees 15 left over from the previous sweep.
        delay_mode = 1'b1;
        run_sweep(0, 2, 0, 16, 0, "dly_settle1");

        // Same block with SETTLE=3 settles in time.
        run_sweep(1, 4, 0, 0, 0, "dly_settle3");

        // Abort mid-sweep at stim=5, then a clean sweep.
        delay_mode = 1'b0;
        foreach (mask[i]) mask[i] = 2'b00;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        w = 0;
        while (stim0 != 4'd5 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("abort_reach5", stim0, 5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out", {stim0, busy0, done0, pass0, err0, ff0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, 2, 0, 0, 0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking response collector for small combinational blocks on the board. It sweeps every input code 0 .. 2^N_IN-1 onto the block under test and samples the block's outputs after a programmable settle time. Each sample is compared against a packed expected truth table. It reports pass/fail, the mismatch count and the first failing code, replacing manual waveform inspection of exhaustive sweeps.

## Interface

Parameters:
- N_IN, 4: number of DUT inputs; sweep covers 2^N_IN codes.
- N_OUT, 2: number of DUT outputs.
- EXPECTED, 32'hE4E4_E4E4: packed truth table, width 2^N_IN*N_OUT. The expected response for code c is EXPECTED[c*N_OUT +: N_OUT]. The default encodes resp = stim[1:0].
- SETTLE, 1: cycles each code is held before sampling; legal range >= 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock domain only.
- start  in  1  level-sampled request to begin a sweep; honoured only in IDLE.
- stim  out  N_IN  code driven to DUT inputs (stim[N_IN-1] = a ... stim[0] = d).
- resp  in  N_OUT  DUT outputs (resp[N_OUT-1] = x ... resp[0] = y); treated as synchronous to clk.
- busy  out  1  high from the first APPLY cycle through the DONE cycle.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  1 iff the last completed sweep had zero mismatches.
- err_count  out  N_IN+1  mismatches in the current/last sweep; max 2^N_IN, never wraps.
- first_fail  out  N_IN  lowest code that mismatched; valid only when err_count != 0.

## Operation

- Reset (async assert, sync release): state=IDLE. All outputs are 0: stim, busy, done, pass, err_count, first_fail. The settle counter is 0.
- IDLE:
  - start=1 -> APPLY. Same edge: stim=0, busy=1, err_count=0, first_fail=0, pass=0, settle counter=0.
  - start=0 -> stay. Results hold.
- APPLY:
  - stim held.
  - The settle counter increments each cycle.
  - After SETTLE cycles in APPLY -> CHECK.
- CHECK, one cycle:
  - resp is compared with the EXPECTED slice for the current stim.
  - On mismatch, err_count increments. If err_count was 0, first_fail=stim.
  - If stim != 2^N_IN-1: stim increments, settle counter clears -> APPLY.
  - Else -> DONE. Same edge: done=1, pass=(final err_count==0), with the comparison of the last code included.
- DONE, one cycle: done=1, busy=1. Unconditionally -> IDLE. Next edge: done=0, busy=0. stim stays at 2^N_IN-1.
- start while busy, including the DONE cycle, is ignored; no queuing.
- stim never wraps mid-sweep; the last code is checked exactly once.
- Reset mid-sweep aborts immediately to reset values; the partial results are discarded.

## Timing

- Per code: SETTLE cycles in APPLY + 1 cycle in CHECK.
- Start accepted at edge k. done is high in the cycle after edge k + 2^N_IN*(SETTLE+1).
  - Defaults: done is high after edge k+32; busy is high for 33 cycles.
- Sampling point: resp is sampled at the end of the CHECK cycle, i.e. SETTLE+1 cycles after stim changed. The DUT path plus any registering must fit in that window.
- pass, err_count and first_fail are stable from the DONE cycle until the next accepted start.
- Back-to-back: earliest new start is accepted in the first IDLE cycle after DONE.

## Test plan

- Reset: hold rst_n=0 with start=1 -> all outputs 0. Release rst_n, start=0 -> stays IDLE, busy=0.
- Loopback: resp = stim[1:0], defaults, pulse start -> stim steps 0..15, each code held 2 cycles. done pulses once after edge k+32; pass=1, err_count=0.
- Stuck-at: resp=2'b00 constant, defaults -> 12 mismatches (every code with stim[1:0]!=0). Result: err_count=12, first_fail=4'h1, pass=0.
- Single fault: loopback, except resp inverted when stim=4'hA -> err_count=1, first_fail=4'hA, pass=0.
- Robustness:
  - Pulse start repeatedly while busy -> exactly one done.
  - Assert rst_n=0 while stim=5 -> all outputs 0 immediately.
  - A new start then gives a clean full sweep: pass=1 with loopback.
- SETTLE=3, resp = stim[1:0] delayed by 2 registers -> pass=1, done after edge k+64. The same DUT with SETTLE=1 -> pass=0, err_count>0.
